// File: rtl/fp16_mult_norm_round_if.sv
// Handshake and data bundle for the float16 post-multiply stage.
// Upstream side (significand multiplier) and downstream side (writeback)
// share one interface; the block itself uses the slave modport.
interface fp16_mult_norm_round_if;
    logic              in_valid;
    logic              in_ready;
    logic [21:0]       prod;
    logic              sign;
    logic signed [6:0] exp_sum;
    logic              in_zero;
    logic              in_inf;
    logic              in_nan;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       result;
    logic              overflow;
    logic              underflow;
    logic              inexact;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, prod, sign, exp_sum, in_zero, in_inf, in_nan, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, inexact
    );

    // The normalize/round block.
    modport slave (
        input  in_valid, prod, sign, exp_sum, in_zero, in_inf, in_nan, out_ready,
        output in_ready, out_valid, result, overflow, underflow, inexact
    );
endinterface

// File: rtl/fp16_mult_norm_round.sv
// Float16 multiplier post-processing: normalizes the 22-bit significand
// product, rounds to nearest-even, applies overflow / flush-to-zero and
// special-value handling, and packs a binary16 result.
// Two registered stages (normalize, round/pack) with valid/ready flow control.
module fp16_mult_norm_round #(
    parameter logic [15:0] QNAN = 16'h7E00
) (
    input  logic                  clk,
    input  logic                  rst,
    fp16_mult_norm_round_if.slave bus
);

    typedef enum logic [1:0] {
        CLS_NUM  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    // Rounds the normalized significand, resolves the exponent range and
    // special classes. Returns {result[15:0], overflow, underflow, inexact}.
    function automatic logic [18:0] round_pack(
        input logic              sgn,
        input logic [9:0]        mant,
        input logic              g,
        input logic              s,
        input logic signed [7:0] e,
        input cls_e              cls
    );
        logic              up;
        logic [10:0]       sum;
        logic [9:0]        m;
        logic signed [7:0] er;
        logic [18:0]       r;
        up  = g & (s | mant[0]);
        sum = {1'b0, mant} + {10'd0, up};
        // A carry out of the fraction means 1.111..1 rounded to 10.0: renormalize.
        if (sum[10]) begin
            m  = 10'd0;
            er = e + 8'sd1;
        end else begin
            m  = sum[9:0];
            er = e;
        end
        case (cls)
            CLS_NAN:  r = {QNAN, 3'b000};
            CLS_INF:  r = {sgn, 5'h1F, 10'h000, 3'b000};
            CLS_ZERO: r = {sgn, 15'h0000, 3'b000};
            default: begin
                if (er >= 8'sd31) begin
                    r = {sgn, 5'h1F, 10'h000, 3'b101};
                end else if (er <= 8'sd0) begin
                    r = {sgn, 15'h0000, 3'b011};
                end else begin
                    r = {sgn, er[4:0], m, 2'b00, g | s};
                end
            end
        endcase
        return r;
    endfunction

    logic s1_ready;
    logic s2_ready;

    // Stage 1 state
    logic              vld_p1_d, vld_p1_q;
    logic [9:0]        mant_p1_d, mant_p1_q;
    logic              g_p1_d, g_p1_q;
    logic              s_p1_d, s_p1_q;
    logic signed [7:0] e_p1_d, e_p1_q;
    logic              sign_p1_d, sign_p1_q;
    cls_e              cls_p1_d, cls_p1_q;

    // Stage 2 state
    logic        out_valid_d, out_valid_q;
    logic [15:0] result_d, result_q;
    logic        overflow_d, overflow_q;
    logic        underflow_d, underflow_q;
    logic        inexact_d, inexact_q;

    logic signed [7:0] exp_ext;
    logic [18:0]       packed_p2;

    assign s2_ready = !out_valid_q || bus.out_ready;
    assign s1_ready = !vld_p1_q || s2_ready;
    assign exp_ext  = {bus.exp_sum[6], bus.exp_sum};

    // Stage 1: select the leading-one position and split into mantissa, guard, sticky.
    always_comb begin
        vld_p1_d  = vld_p1_q;
        mant_p1_d = mant_p1_q;
        g_p1_d    = g_p1_q;
        s_p1_d    = s_p1_q;
        e_p1_d    = e_p1_q;
        sign_p1_d = sign_p1_q;
        cls_p1_d  = cls_p1_q;
        if (s1_ready) begin
            vld_p1_d = bus.in_valid;
        end
        if (s1_ready && bus.in_valid) begin
            sign_p1_d = bus.sign;
            if (bus.prod[21]) begin
                mant_p1_d = bus.prod[20:11];
                g_p1_d    = bus.prod[10];
                s_p1_d    = |bus.prod[9:0];
                e_p1_d    = exp_ext + 8'sd1;
            end else begin
                mant_p1_d = bus.prod[19:10];
                g_p1_d    = bus.prod[9];
                s_p1_d    = |bus.prod[8:0];
                e_p1_d    = exp_ext;
            end
            if (bus.in_nan || (bus.in_inf && bus.in_zero)) begin
                cls_p1_d = CLS_NAN;
            end else if (bus.in_inf) begin
                cls_p1_d = CLS_INF;
            end else if (bus.in_zero || (bus.prod[21:20] == 2'b00)) begin
                cls_p1_d = CLS_ZERO;
            end else begin
                cls_p1_d = CLS_NUM;
            end
        end
    end

    assign packed_p2 = round_pack(sign_p1_q, mant_p1_q, g_p1_q, s_p1_q, e_p1_q, cls_p1_q);

    // Stage 2: round, range-check and pack; hold while the consumer stalls.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;
        if (s2_ready) begin
            out_valid_d = vld_p1_q;
        end
        if (s2_ready && vld_p1_q) begin
            result_d    = packed_p2[18:3];
            overflow_d  = packed_p2[2];
            underflow_d = packed_p2[1];
            inexact_d   = packed_p2[0];
        end
    end

    // Control and visible outputs: cleared by reset so in-flight beats are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= 16'h0000;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            inexact_q   <= inexact_d;
        end
    end

    // Stage 1 datapath: qualified by vld_p1_q, so no reset is needed.
    always_ff @(posedge clk) begin
        mant_p1_q <= mant_p1_d;
        g_p1_q    <= g_p1_d;
        s_p1_q    <= s_p1_d;
        e_p1_q    <= e_p1_d;
        sign_p1_q <= sign_p1_d;
        cls_p1_q  <= cls_p1_d;
    end

    assign bus.in_ready  = s1_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.inexact   = inexact_q;

endmodule

// File: tb/tb_fp16_mult_norm_round.sv
// Bench for fp16_mult_norm_round: directed vectors with hand-computed results,
// expected values queued at acceptance and checked by an independent monitor.
module tb_fp16_mult_norm_round;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp16_mult_norm_round_if bus ();

    fp16_mult_norm_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {result, overflow, underflow, inexact}
    logic [18:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_out  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic set_in(input logic [21:0] p, input logic [6:0] e, input logic s,
                          input logic z, input logic i, input logic n);
        bus.in_valid = 1'b1;
        bus.prod     = p;
        bus.exp_sum  = e;
        bus.sign     = s;
        bus.in_zero  = z;
        bus.in_inf   = i;
        bus.in_nan   = n;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Called at a drive point (just after a rising edge); returns at the drive
    // point after the beat is accepted.
    task automatic send(input logic [21:0] p, input logic [6:0] e, input logic s,
                        input logic z, input logic i, input logic n, input logic [18:0] want);
        bit done = 1'b0;
        set_in(p, e, s, z, i, n);
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(want);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for prod=%h", p);
        end
    endtask

    // Monitor: every result the DUT hands over is checked against the queue.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            logic [18:0] got;
            logic [18:0] want;
            got = {bus.result, bus.overflow, bus.underflow, bus.inexact};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got res=%h flags=%b, expected none", got[18:3], got[2:0]);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL out[%0d]: got res=%h ovf/unf/inx=%b, expected res=%h ovf/unf/inx=%b",
                             n_out, got[18:3], got[2:0], want[18:3], want[2:0]);
                end
            end
            n_out++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.prod      = '0;
        bus.exp_sum   = '0;
        bus.sign      = 1'b0;
        bus.in_zero   = 1'b0;
        bus.in_inf    = 1'b0;
        bus.in_nan    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'h0000);
        check("rst_flags", 32'({bus.overflow, bus.underflow, bus.inexact}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1.0 x 1.0 with latency check
        send(22'h100000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h3C00, 3'b000});
        idle();
        @(negedge clk);
        check("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors
        send(22'h240000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h4080, 3'b000});
        send(22'h100200, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h3C00, 3'b001});
        send(22'h100600, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h3C02, 3'b001});
        send(22'h1FFE00, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h4000, 3'b001});
        send(22'h3FFFFF, 7'd30, 1'b1, 1'b0, 1'b0, 1'b0, {16'hFC00, 3'b101});
        send(22'h100000, 7'd0,  1'b1, 1'b0, 1'b0, 1'b0, {16'h8000, 3'b011});
        send(22'h200000, 7'd30, 1'b0, 1'b0, 1'b0, 1'b0, {16'h7C00, 3'b101});
        send(22'h100000, 7'd30, 1'b0, 1'b0, 1'b0, 1'b0, {16'h7800, 3'b000});
        send(22'h100000, 7'd1,  1'b0, 1'b0, 1'b0, 1'b0, {16'h0400, 3'b000});
        send(22'h200000, 7'h7F, 1'b0, 1'b0, 1'b0, 1'b0, {16'h0000, 3'b011});
        send(22'h300000, 7'h7B, 1'b1, 1'b0, 1'b0, 1'b0, {16'h8000, 3'b011});
        send(22'h100000, 7'd15, 1'b0, 1'b1, 1'b1, 1'b0, {16'h7E00, 3'b000});
        send(22'h100000, 7'd15, 1'b1, 1'b0, 1'b1, 1'b0, {16'hFC00, 3'b000});
        send(22'h3FFFFF, 7'd40, 1'b1, 1'b0, 1'b0, 1'b1, {16'h7E00, 3'b000});
        send(22'h100000, 7'd15, 1'b1, 1'b1, 1'b0, 1'b0, {16'h8000, 3'b000});
        send(22'h000000, 7'd20, 1'b0, 1'b0, 1'b0, 1'b0, {16'h0000, 3'b000});
        send(22'h100000, 7'd15, 1'b0, 1'b0, 1'b1, 1'b1, {16'h7E00, 3'b000});
        idle();
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        // Backpressure: two beats fill the pipe, the third is refused
        bus.out_ready = 1'b0;
        send(22'h100000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h3C00, 3'b000});
        send(22'h240000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h4080, 3'b000});
        set_in(22'h100600, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_result", 32'(bus.result), 32'h3C00);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_valid0", 32'(bus.out_valid), 32'd1);
        if (bus.in_ready) exp_q.push_back({16'h3C02, 3'b001});
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        check("release_valid1", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("release_valid2", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("release_drained", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a stall drops the in-flight beats
        bus.out_ready = 1'b0;
        send(22'h240000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h4080, 3'b000});
        send(22'h1FFE00, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h4000, 3'b001});
        idle();
        @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_result", 32'(bus.result), 32'h0000);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rst_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_release_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(22'h100600, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h3C02, 3'b001});
        idle();

        // Drain
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
